led_sequencer: RTL

- Downstream consumer of the timer's `elapsed` pulse.
- Drives an LED bank through a selectable display pattern, advancing one step per timer tick.
- A debounced mode button cycles the pattern: OFF, BLINK, CHASE, PINGPONG.
- Also generates the timer's `enabled` input, so the timer runs only while a pattern is active.

---
 rtl/led_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// led_sequencer
//   Steps an LED bank through a display pattern, one step per timer tick.
//   A mode button cycles OFF -> BLINK -> CHASE -> PINGPONG -> OFF. The
//   sequencer also drives the timer's enable, so the timer runs only while
//   a pattern is active.
//
// Ports
//   clock          in   system clock
//   reset_s2       in   asynchronous active-high reset
//   tick           in   one-cycle step pulse from the timer
//   mode_button    in   debounced, synchronized mode button level
//   timer_enabled  out  registered, 1 whenever mode != OFF
//   mode           out  0 = OFF, 1 = BLINK, 2 = CHASE, 3 = PINGPONG
//   leds           out  LED drive, bit 0 = rightmost, 1 = lit
module led_sequencer #(
  parameter int LED_COUNT = 4
) (
  input  logic                 clock,
  input  logic                 reset_s2,
  input  logic                 tick,
  input  logic                 mode_button,
  output logic                 timer_enabled,
  output logic [1:0]           mode,
  output logic [LED_COUNT-1:0] leds
);

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_BLINK    = 2'd1,
    MODE_CHASE    = 2'd2,
    MODE_PINGPONG = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [LED_COUNT-1:0] LEDS_RIGHT = LED_COUNT'(1);

  mode_t                r_mode;
  mode_t                w_mode_next;
  dir_t                 r_dir;
  dir_t                 w_dir_next;
  logic [LED_COUNT-1:0] r_leds;
  logic [LED_COUNT-1:0] w_leds_next;
  logic [LED_COUNT-1:0] w_shift;
  logic                 r_button_prev;
  logic                 r_timer_en;
  logic                 w_press;

  // Rising edge of the button level: one cycle per press however long it is held.
  assign w_press = mode_button & ~r_button_prev;

  always_ff @(posedge clock or posedge reset_s2) begin
    if (reset_s2) begin
      r_mode        <= MODE_OFF;
      r_dir         <= DIR_UP;
      r_leds        <= '0;
      r_button_prev <= 1'b0;
      r_timer_en    <= 1'b0;
    end else begin
      r_mode        <= w_mode_next;
      r_dir         <= w_dir_next;
      r_leds        <= w_leds_next;
      r_button_prev <= mode_button;
      r_timer_en    <= (w_mode_next != MODE_OFF);
    end
  end

  // A press takes priority over a tick in the same cycle: the entry pattern
  // loads and the tick is dropped.
  always_comb begin
    w_mode_next = r_mode;
    w_dir_next  = r_dir;
    w_leds_next = r_leds;
    w_shift     = '0;
    if (w_press) begin
      case (r_mode)
        MODE_OFF: begin
          w_mode_next = MODE_BLINK;
          w_leds_next = '1;
        end
        MODE_BLINK: begin
          w_mode_next = MODE_CHASE;
          w_leds_next = LEDS_RIGHT;
        end
        MODE_CHASE: begin
          w_mode_next = MODE_PINGPONG;
          w_leds_next = LEDS_RIGHT;
          w_dir_next  = DIR_UP;
        end
        default: begin
          w_mode_next = MODE_OFF;
          w_leds_next = '0;
        end
      endcase
    end else if (tick) begin
      case (r_mode)
        MODE_BLINK: w_leds_next = ~r_leds;
        MODE_CHASE: w_leds_next = {r_leds[LED_COUNT-2:0], r_leds[LED_COUNT-1]};
        MODE_PINGPONG: begin
          // Direction flips on the same edge the endpoint is reached, so
          // each endpoint is shown for exactly one tick.
          if (r_dir == DIR_UP) begin
            w_shift = r_leds << 1;
            if (w_shift[LED_COUNT-1]) w_dir_next = DIR_DOWN;
          end else begin
            w_shift = r_leds >> 1;
            if (w_shift[0]) w_dir_next = DIR_UP;
          end
          w_leds_next = w_shift;
        end
        default: w_leds_next = '0;
      endcase
    end
  end

  assign mode          = r_mode;
  assign leds          = r_leds;
  assign timer_enabled = r_timer_en;

endmodule
